// File: rtl/cpu_run_ctrl_if.sv
// Run-control bundle: button levels and core halt request in,
// core clock-enable, run state and retired-instruction count out.
interface cpu_run_ctrl_if;
  logic        btn_run;
  logic        btn_step;
  logic        btn_halt;
  logic        halt_req;
  logic        cpu_ce;
  logic [1:0]  state;
  logic [31:0] instr_count;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
  logic [31:0] pc;
  logic [31:0] bp_addr;
  logic        bp_en;
  logic        bp_hit;

  modport master (
    output btn_run, btn_step, btn_halt, halt_req,
    output pc, bp_addr, bp_en,
    input  cpu_ce, state, instr_count, bp_hit
  );
  modport slave (
    input  btn_run, btn_step, btn_halt, halt_req,
    input  pc, bp_addr, bp_en,
    output cpu_ce, state, instr_count, bp_hit
  );
`else
  modport master (
    output btn_run, btn_step, btn_halt, halt_req,
    input  cpu_ce, state, instr_count
  );
  modport slave (
    input  btn_run, btn_step, btn_halt, halt_req,
    output cpu_ce, state, instr_count
  );
`endif
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt controller gating the single-cycle core clock-enable.
// Define CPU_RUN_CTRL_BREAKPOINT_EN to add a single PC breakpoint.
module cpu_run_ctrl #(
  parameter int unsigned RUN_DIV     = 1,
  parameter int unsigned STEP_CYCLES = 1
) (
  input  logic         clk,
  input  logic         reset,
  cpu_run_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    STEP   = 2'b10,
    HALTED = 2'b11
  } state_t;

  localparam logic [15:0] DIV_MAX  = 16'(RUN_DIV - 1);
  localparam logic [7:0]  STEP_MAX = 8'(STEP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [7:0]  step_q, step_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  hist_q, hist_d;

  logic ev_halt, ev_step, ev_run;
  logic active, bp_stop, stop, cpu_ce;

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
  logic bp_hit_q, bp_hit_d;

  assign bp_stop = (state_q == RUN) & bus.bp_en
                 & (bus.pc == bus.bp_addr);

  always_comb begin
    bp_hit_d = bp_hit_q;
    if (state_q == RUN && stop)
      bp_hit_d = bp_stop;
    else if (state_q == HALTED && ev_halt)
      bp_hit_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) bp_hit_q <= 1'b0;
    else       bp_hit_q <= bp_hit_d;
  end

  assign bus.bp_hit = bp_hit_q;
`else
  assign bp_stop = 1'b0;
`endif

  // Events are priority-resolved here: halt > step > run.
  assign ev_halt = bus.btn_halt & ~hist_q[2];
  assign ev_step = bus.btn_step & ~hist_q[1] & ~ev_halt;
  assign ev_run  = bus.btn_run  & ~hist_q[0] & ~ev_halt & ~ev_step;

  assign active = (state_q == RUN) | (state_q == STEP);
  assign stop   = (active & bus.halt_req) | bp_stop;

  assign cpu_ce = ~reset & ~bus.halt_req & ~bp_stop
                & (((state_q == RUN) & (div_q == DIV_MAX))
                   | (state_q == STEP));

  always_comb begin
    hist_d  = {bus.btn_halt, bus.btn_step, bus.btn_run};
    state_d = state_q;
    div_d   = div_q;
    step_d  = step_q;
    cnt_d   = cnt_q + 32'(cpu_ce);
    unique case (state_q)
      IDLE: begin
        if (ev_step) begin
          state_d = STEP;
          step_d  = '0;
        end else if (ev_run) begin
          state_d = RUN;
          div_d   = '0;
        end
      end
      RUN: begin
        if (stop)
          state_d = HALTED;
        else if (ev_halt)
          state_d = IDLE;
        else if (div_q == DIV_MAX)
          div_d = '0;
        else
          div_d = div_q + 16'd1;
      end
      STEP: begin
        if (stop)
          state_d = HALTED;
        else if (step_q == STEP_MAX)
          state_d = IDLE;
        else
          step_d = step_q + 8'd1;
      end
      HALTED: begin
        if (ev_halt)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // History resets high so a button held through reset is not an event.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
      hist_q  <= '1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      hist_q  <= hist_d;
    end
  end

  assign bus.cpu_ce      = cpu_ce;
  assign bus.state       = state_q;
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: expected cpu_ce pulses are queued
// by the stimulus and popped by a monitor on every observed pulse.
module tb_cpu_run_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  typedef struct {
    int          c;
    logic [31:0] n;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] n0 = 0;
  logic [31:0] n1 = 0;

  cpu_run_ctrl_if bus0();
  cpu_run_ctrl_if bus1();

  cpu_run_ctrl #(.RUN_DIV(4), .STEP_CYCLES(1)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  cpu_run_ctrl #(.RUN_DIV(4), .STEP_CYCLES(3)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic exp0(input int c);
    q0.push_back(exp_t'{c, n0});
    n0++;
  endtask

  task automatic exp1(input int c);
    q1.push_back(exp_t'{c, n1});
    n1++;
  endtask

  // 0 = run, 1 = step, 2 = halt; one-cycle press on dut0
  task automatic press(input int which);
    case (which)
      0: bus0.btn_run  = 1'b1;
      1: bus0.btn_step = 1'b1;
      default: bus0.btn_halt = 1'b1;
    endcase
    @(negedge clk);
    bus0.btn_run  = 1'b0;
    bus0.btn_step = 1'b0;
    bus0.btn_halt = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (bus0.cpu_ce === 1'b1) begin
      if (q0.size() == 0) begin
        chk("ce0_unexpected", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        e = q0.pop_front();
        chk("ce0_cycle", 32'(cyc), 32'(e.c));
        chk("ce0_count", bus0.instr_count, e.n);
      end
    end
    if (bus1.cpu_ce === 1'b1) begin
      if (q1.size() == 0) begin
        chk("ce1_unexpected", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        e = q1.pop_front();
        chk("ce1_cycle", 32'(cyc), 32'(e.c));
        chk("ce1_count", bus1.instr_count, e.n);
      end
    end
  end

  initial begin
    int c, k;
    reset         = 1'b1;
    bus0.btn_run  = 1'b1;
    bus0.btn_step = 1'b0;
    bus0.btn_halt = 1'b0;
    bus0.halt_req = 1'b0;
    bus1.btn_run  = 1'b0;
    bus1.btn_step = 1'b0;
    bus1.btn_halt = 1'b0;
    bus1.halt_req = 1'b0;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    bus0.pc      = 32'h0;
    bus0.bp_addr = 32'h0;
    bus0.bp_en   = 1'b0;
    bus1.pc      = 32'h0;
    bus1.bp_addr = 32'h0;
    bus1.bp_en   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(bus0.state), 32'd0);
    chk("rst_ce", 32'(bus0.cpu_ce), 32'd0);
    chk("rst_cnt", bus0.instr_count, 32'd0);
    reset = 1'b0;

    // run held through reset release: no event
    repeat (20) @(negedge clk);
    chk("hold_state", 32'(bus0.state), 32'd0);
    chk("hold_cnt", bus0.instr_count, 32'd0);
    bus0.btn_run = 1'b0;
    @(negedge clk);

    // single step
    exp0(cyc + 1);
    press(1);
    chk("step_state", 32'(bus0.state), 32'd2);
    @(negedge clk);
    chk("step_done", 32'(bus0.state), 32'd0);
    chk("step_cnt", bus0.instr_count, 32'd1);

    // run for 40 cycles, then halt button
    c = cyc;
    k = c + 1;
    for (int i = 0; i < 10; i++) exp0(k + 3 + 4 * i);
    press(0);
    chk("run_state", 32'(bus0.state), 32'd1);
    repeat (40) @(negedge clk);
    chk("run_cnt", bus0.instr_count, 32'd11);
    press(2);
    chk("run_halt_state", 32'(bus0.state), 32'd0);
    repeat (10) @(negedge clk);
    chk("run_halt_cnt", bus0.instr_count, 32'd11);

    // halt_req on a divider==3 cycle
    c = cyc;
    k = c + 1;
    exp0(k + 3);
    exp0(k + 7);
    press(0);
    repeat (11) @(negedge clk);
    bus0.halt_req = 1'b1;
    @(negedge clk);
    bus0.halt_req = 1'b0;
    chk("hreq_state", 32'(bus0.state), 32'd3);
    press(0);
    chk("halted_run_ign", 32'(bus0.state), 32'd3);
    press(1);
    chk("halted_step_ign", 32'(bus0.state), 32'd3);
    press(2);
    chk("halted_exit", 32'(bus0.state), 32'd0);
    chk("hreq_cnt", bus0.instr_count, 32'd13);

    // run and step rising together: step wins
    exp0(cyc + 1);
    bus0.btn_run  = 1'b1;
    bus0.btn_step = 1'b1;
    @(negedge clk);
    chk("coinc_state", 32'(bus0.state), 32'd2);
    bus0.btn_run  = 1'b0;
    bus0.btn_step = 1'b0;
    @(negedge clk);
    chk("coinc_done", 32'(bus0.state), 32'd0);

    // halt button and halt_req together in RUN: halt_req wins
    press(0);
    bus0.btn_halt = 1'b1;
    bus0.halt_req = 1'b1;
    @(negedge clk);
    bus0.btn_halt = 1'b0;
    bus0.halt_req = 1'b0;
    chk("hh_state", 32'(bus0.state), 32'd3);
    @(negedge clk);
    press(2);
    chk("hh_exit", 32'(bus0.state), 32'd0);

    // halt_req during STEP suppresses the pulse
    bus0.halt_req = 1'b1;
    press(1);
    chk("step_hreq_in", 32'(bus0.state), 32'd2);
    @(negedge clk);
    chk("step_hreq_st", 32'(bus0.state), 32'd3);
    bus0.halt_req = 1'b0;
    press(2);
    chk("step_hreq_exit", 32'(bus0.state), 32'd0);
    chk("step_hreq_cnt", bus0.instr_count, 32'd14);

    // STEP_CYCLES=3 instance
    c = cyc;
    exp1(c + 1);
    exp1(c + 2);
    exp1(c + 3);
    bus1.btn_step = 1'b1;
    @(negedge clk);
    bus1.btn_step = 1'b0;
    chk("s3_state_a", 32'(bus1.state), 32'd2);
    repeat (2) @(negedge clk);
    chk("s3_state_b", 32'(bus1.state), 32'd2);
    @(negedge clk);
    chk("s3_done", 32'(bus1.state), 32'd0);
    chk("s3_cnt", bus1.instr_count, 32'd3);

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    bus0.bp_en   = 1'b1;
    bus0.bp_addr = 32'h10;
    bus0.pc      = 32'h0;
    c = cyc;
    k = c + 1;
    exp0(k + 3);
    press(0);
    repeat (5) @(negedge clk);
    bus0.pc = 32'h10;
    @(negedge clk);
    chk("bp_state", 32'(bus0.state), 32'd3);
    chk("bp_hit_set", 32'(bus0.bp_hit), 32'd1);
    bus0.pc    = 32'h0;
    bus0.bp_en = 1'b0;
    press(2);
    chk("bp_exit", 32'(bus0.state), 32'd0);
    chk("bp_hit_clr", 32'(bus0.bp_hit), 32'd0);
`endif

    repeat (4) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 SHALL have parameter RUN_DIV, default 1: core clock-enable period in RUN, in clk cycles; legal range 1..65535.
REQ-002 SHALL have parameter STEP_CYCLES, default 1: cpu_ce cycles issued per STEP; legal range 1..255.
REQ-003 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port btn_run  input  1  debounced run button level.
REQ-006 SHALL have port btn_step  input  1  debounced step button level.
REQ-007 SHALL have port btn_halt  input  1  debounced halt button level.
REQ-008 SHALL have port halt_req  input  1  core halt request (ebreak/ecall decode).
REQ-009 SHALL have port cpu_ce  output  1  clock-enable to the single-cycle core.
REQ-010 SHALL have port state  output  2  IDLE=00, RUN=01, STEP=10, HALTED=11.
REQ-011 SHALL have port instr_count  output  32  number of cpu_ce cycles since reset.

Function
REQ-012 SHALL register each btn_* into a history flop; press event = btn & ~history, one cycle wide.
REQ-013 SHALL apply event priority when events coincide: halt > step > run.
REQ-014 SHALL implement IDLE: step event -> STEP; run event -> RUN; halt event ignored.
REQ-015 SHALL implement RUN: divider counts 0..RUN_DIV-1 and wraps; halt event -> IDLE; step/run events ignored.
REQ-016 SHALL implement STEP: occupy exactly STEP_CYCLES cycles, then -> IDLE; all button events ignored.
REQ-017 SHALL implement HALTED: halt event -> IDLE; run/step events ignored.
REQ-018 SHALL zero the divider on RUN entry and the step counter on STEP entry.
REQ-019 SHALL drive cpu_ce combinationally = (RUN & divider==RUN_DIV-1 | STEP) & ~halt_req.
REQ-020 SHALL, when halt_req is high in RUN or STEP, force cpu_ce low that cycle and enter HALTED on the next edge; this overrides button events and STEP completion.
REQ-021 SHALL ignore halt_req in IDLE and HALTED.
REQ-022 SHALL, for an event present in the cycle before edge k, update state at edge k; the first STEP cpu_ce is the cycle after edge k; the first RUN cpu_ce is RUN_DIV cycles after edge k.
REQ-023 SHALL increment instr_count by 1 on every edge where cpu_ce is high, wrapping 0xFFFFFFFF -> 0.
REQ-024 SHALL issue STEP_CYCLES cpu_ce pulses per STEP with no gap when halt_req stays low.

Reset
REQ-025 SHALL, with reset high, set state=IDLE, divider=0, step counter=0, instr_count=0 and cpu_ce=0.
REQ-026 SHALL set all button history flops to 1 during reset, so a button held across reset release generates no event.
REQ-027 SHALL abort any RUN or STEP in progress when reset asserts; no cpu_ce is issued in the reset cycle.

Configuration
REQ-028 SHALL compile breakpoint support only when macro CPU_RUN_CTRL_BREAKPOINT_EN is defined.
REQ-029 SHALL, with the macro defined, add inputs pc[31:0] and bp_addr[31:0], bp_en[0:0] and output bp_hit[0:0].
REQ-030 SHALL, with the macro defined, treat (RUN & bp_en & pc==bp_addr) like halt_req: cpu_ce low, -> HALTED, bp_hit high while in HALTED due to breakpoint.
REQ-031 SHALL clear bp_hit on reset and when leaving HALTED.
REQ-032 SHALL, without the macro, omit these ports and logic entirely; all other behaviour is unchanged.

Verification (RUN_DIV=4, STEP_CYCLES=1 unless stated)
REQ-033 SHALL cover: btn_run held high through reset release -> state stays 00, cpu_ce 0, instr_count 0 for 20 cycles.
REQ-034 SHALL cover: single btn_step press -> exactly 1 cpu_ce pulse, instr_count=1, state 10 then 00; with STEP_CYCLES=3 -> 3 consecutive pulses, instr_count=3.
REQ-035 SHALL cover: btn_run press, 40 cycles in RUN -> 10 pulses spaced 4 cycles apart, instr_count=10; then btn_halt press -> state 00 and no further pulses.
REQ-036 SHALL cover: halt_req=1 on a divider==3 cycle in RUN -> cpu_ce 0 that cycle, state 11; run press ignored; halt press -> 00.
REQ-037 SHALL cover: btn_run and btn_step rising in the same cycle in IDLE -> state 10; btn_halt and halt_req together in RUN -> state 11.
REQ-038 SHALL cover: with the macro defined, bp_en=1, bp_addr=0x10, pc reaching 0x10 in RUN -> cpu_ce 0, state 11, bp_hit 1; halt press -> bp_hit 0.
